// File: rtl/led_fade_pkg.sv
// Shared defaults and helpers for the LED trail fader: channel count,
// brightness resolution, per-step decay and the saturating decrement.
package led_fade_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_LEVEL_BITS = 4;
  localparam int DEF_LEVEL_MAX  = (1 << DEF_LEVEL_BITS) - 1;
  localparam int DEF_DECAY      = 4;

  // Clamps at zero so a dim LED never wraps back to a bright level.
  function automatic int unsigned sat_dec(input int unsigned lvl, input int unsigned dec);
    return (lvl > dec) ? (lvl - dec) : 32'd0;
  endfunction

endpackage

// File: rtl/led_trail_fader_if.sv
// Scanner-side and LED-side signals of the trail fader, grouped for
// connection between a pattern source (master) and the fader (slave).
interface led_trail_fader_if
  import led_fade_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  // step is a one-cycle strobe with no backpressure: pattern_in is only
  // meaningful while step is 1, and the fader always accepts it (a step
  // that lands on an unapplied one replaces it and raises overrun).
  logic             step;
  logic [WIDTH-1:0] pattern_in;
  logic             enable;
  logic [WIDTH-1:0] led_out;
  logic             frame_tick;
  logic             overrun;

  modport master (
    output step, pattern_in, enable,
    input  led_out, frame_tick, overrun
  );

  modport slave (
    input  step, pattern_in, enable,
    output led_out, frame_tick, overrun
  );

endinterface

// File: rtl/led_pwm_channel.sv
// One LED: brightness level register, refresh/decay update on an applied
// step, and a registered PWM compare against the shared frame counter.
module led_pwm_channel
  import led_fade_pkg::*;
#(
  parameter int          LEVEL_BITS = DEF_LEVEL_BITS,
  parameter int unsigned DECAY      = DEF_DECAY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  apply,
  input  logic                  lit,
  input  logic                  enable,
  input  logic [LEVEL_BITS-1:0] pwm_cnt,
  output logic                  led
);

  localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;

  logic [LEVEL_BITS-1:0] level_q;

  // Levels only move on the frame's last cycle, so the next frame's compare
  // starts at pwm_cnt==0 with the new value and never changes mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      led     <= 1'b0;
    end else begin
      if (apply) begin
        level_q <= lit ? LEVEL_MAX : LEVEL_BITS'(sat_dec(32'(level_q), DECAY));
      end
      led <= (level_q > pwm_cnt) && enable;
    end
  end

endmodule

// File: rtl/led_trail_fader.sv
// Scanner trail fader: latches scanner patterns, applies them once per PWM
// frame (lit LEDs to full, others decay) and drives PWM-dimmed LED outputs.
module led_trail_fader
  import led_fade_pkg::*;
#(
  parameter int          WIDTH      = DEF_WIDTH,
  parameter int          LEVEL_BITS = DEF_LEVEL_BITS,
  parameter int unsigned DECAY      = DEF_DECAY
) (
  input  logic               clk,
  input  logic               rst_n,
  led_trail_fader_if.slave   bus
);

  localparam logic [LEVEL_BITS-1:0] CNT_LAST = LEVEL_BITS'((1 << LEVEL_BITS) - 2);

  logic [LEVEL_BITS-1:0] pwm_cnt;
  logic [WIDTH-1:0]      pat_q;
  logic                  pend;
  logic                  overrun_q;
  logic                  frame_tick;
  logic                  apply;
  logic [WIDTH-1:0]      led_vec;

  assign frame_tick = bus.enable && (pwm_cnt == CNT_LAST);
  assign apply      = frame_tick && pend;

  // Held at 0 while disabled so re-enabling always starts a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (!bus.enable || (pwm_cnt == CNT_LAST)) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // A step on the applying tick is a fresh pending pattern, not an overrun:
  // the channels consume the old pat_q on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '0;
      pend      <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.step) begin
      pat_q <= bus.pattern_in;
      pend  <= 1'b1;
      if (pend && !apply) begin
        overrun_q <= 1'b1;
      end
    end else if (apply) begin
      pend <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    led_pwm_channel #(
      .LEVEL_BITS (LEVEL_BITS),
      .DECAY      (DECAY)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .apply   (apply),
      .lit     (pat_q[i]),
      .enable  (bus.enable),
      .pwm_cnt (pwm_cnt),
      .led     (led_vec[i])
    );
  end

  assign bus.led_out    = led_vec;
  assign bus.frame_tick = frame_tick;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: per-frame LED duty scoreboard plus direct
// checks of reset, overrun, frame timing and the enable gate.
module tb_led_trail_fader;

  logic clk;
  logic rst_n;

  led_trail_fader_if #(.WIDTH(8)) bus ();

  led_trail_fader #(
    .WIDTH      (8),
    .LEVEL_BITS (4),
    .DECAY      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Each entry: expected on-cycle count per LED over one frame, 4 bits per LED.
  logic [31:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: a frame's outputs end one sample after its frame_tick (led_out
  // is registered). Only clean 15-sample windows are scored.
  int          acc[8];
  int          win_n;
  bit          tick_d;
  logic [31:0] got_duty;
  logic [31:0] exp_duty;

  always @(negedge clk) begin
    if (!rst_n) begin
      win_n  = 0;
      tick_d = 1'b0;
      for (int i = 0; i < 8; i++) acc[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) acc[i] += int'(bus.led_out[i]);
      win_n++;
      if (tick_d) begin
        if (win_n == 15 && exp_q.size() > 0) begin
          got_duty = '0;
          for (int i = 0; i < 8; i++) got_duty[i*4 +: 4] = 4'(acc[i]);
          exp_duty = exp_q.pop_front();
          checks++;
          if (got_duty !== exp_duty) begin
            failures++;
            $display("FAIL frame_duty got=%h exp=%h", got_duty, exp_duty);
          end
        end
        win_n = 0;
        for (int i = 0; i < 8; i++) acc[i] = 0;
      end
      tick_d = bus.frame_tick;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [7:0] pat);
    tick_cycle();
    bus.step       = 1'b1;
    bus.pattern_in = pat;
    tick_cycle();
    bus.step       = 1'b0;
    bus.pattern_in = '0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!bus.frame_tick && n < 40) begin
      tick_cycle();
      n++;
    end
    if (!bus.frame_tick) begin
      checks++;
      failures++;
      $display("FAIL wait_tick got=no_tick exp=tick_within_40");
    end
  endtask

  // Counts cycles from the current one (as 1) to the first frame_tick.
  task automatic measure_tick(output int n);
    n = 1;
    while (!bus.frame_tick && n < 40) begin
      tick_cycle();
      n++;
    end
  endtask

  // Called in a tick cycle: the expectation covers the frame that follows.
  task automatic push_next_frame(input logic [31:0] exp);
    tick_cycle();
    tick_cycle();
    exp_q.push_back(exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      tick_cycle();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d_pending exp=0_pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic step_and_expect(input logic [7:0] pat, input logic [31:0] exp);
    do_step(pat);
    wait_tick();
    push_next_frame(exp);
    drain();
  endtask

  // ---------------- stimulus ----------------
  localparam logic [7:0]  STEP_PAT [5] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08};
  localparam logic [31:0] STEP_EXP [5] = '{32'hF000_0000, 32'hBF00_0000, 32'h7BF0_0000,
                                           32'h37BF_0000, 32'h037B_F000};

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.step       = 1'b0;
    bus.pattern_in = '0;
    bus.enable     = 1'b1;
    repeat (3) tick_cycle();
    check("reset_led_out", 32'(bus.led_out), 32'h0);
    check("reset_overrun", 32'(bus.overrun), 32'h0);
    check("reset_frame_tick", 32'(bus.frame_tick), 32'h0);
    rst_n = 1'b1;
    measure_tick(n);
    check("first_tick_cycles", 32'(n), 32'd15);
    push_next_frame(32'h0);
    drain();

    // Trail walks down: refresh to full, decay by 4, saturate at 0.
    for (int i = 0; i < 5; i++) step_and_expect(STEP_PAT[i], STEP_EXP[i]);

    // Two steps in one frame: the second overwrites the first.
    do_step(8'h01);
    check("overrun_after_one", 32'(bus.overrun), 32'h0);
    do_step(8'h02);
    check("overrun_after_two", 32'(bus.overrun), 32'h1);
    wait_tick();
    push_next_frame(32'h0037_B0F0);
    drain();

    // Mid-frame reset with a pending step and lit LEDs.
    do_step(8'h55);
    tick_cycle();
    rst_n = 1'b0;
    #1;
    check("midreset_led_out", 32'(bus.led_out), 32'h0);
    check("midreset_overrun", 32'(bus.overrun), 32'h0);
    repeat (2) tick_cycle();
    rst_n = 1'b1;
    measure_tick(n);
    check("post_reset_tick_cycles", 32'(n), 32'd15);
    push_next_frame(32'h0);
    drain();

    // Step landing on the applying tick: old pattern now, new one next frame.
    do_step(8'h08);
    wait_tick();
    bus.step       = 1'b1;
    bus.pattern_in = 8'h04;
    tick_cycle();
    bus.step       = 1'b0;
    bus.pattern_in = '0;
    tick_cycle();
    exp_q.push_back(32'h0000_F000);
    check("overrun_on_tick_step", 32'(bus.overrun), 32'h0);
    wait_tick();
    push_next_frame(32'h0000_BF00);
    drain();
    check("overrun_after_tick_apply", 32'(bus.overrun), 32'h0);

    // Disabled for 40 cycles while steps keep arriving.
    tick_cycle();
    bus.enable = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick_cycle();
      check("disabled_led_out", 32'(bus.led_out), 32'h0);
      check("disabled_frame_tick", 32'(bus.frame_tick), 32'h0);
      bus.step       = (k == 10) || (k == 20);
      bus.pattern_in = (k == 10) ? 8'h01 : ((k == 20) ? 8'h80 : 8'h00);
    end
    tick_cycle();
    bus.step       = 1'b0;
    bus.pattern_in = '0;
    check("disabled_overrun", 32'(bus.overrun), 32'h1);
    bus.enable = 1'b1;
    measure_tick(n);
    check("reenable_tick_cycles", 32'(n), 32'd15);
    push_next_frame(32'hF000_7B00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_trail_fader.md
LED_TRAIL_FADER -- requirements
Module: led_trail_fader

Interface
REQ-001 Parameter WIDTH, default 8: number of LED channels.
REQ-002 Parameter LEVEL_BITS, default 4: brightness resolution; LEVEL_MAX = 2^LEVEL_BITS-1 (15).
REQ-003 Parameter DECAY, default 4: levels subtracted per applied update; legal range 1..LEVEL_MAX.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 step  input  1  one-cycle pulse from the upstream scanner; pattern_in is valid in that cycle.
REQ-007 pattern_in  input  WIDTH  current scanner LED pattern; bit i=1 means LED i is lit.
REQ-008 enable  input  1  1 = PWM running; 0 = outputs dark.
REQ-009 led_out  output  WIDTH  PWM-dimmed LED drive, registered.
REQ-010 frame_tick  output  1  one-cycle pulse on the last cycle of each PWM frame.
REQ-011 overrun  output  1  sticky: a step was overwritten before it was applied.

Function
REQ-012 pwm_cnt SHALL count 0..LEVEL_MAX-1, wrapping to 0; frame = LEVEL_MAX cycles (15).
REQ-013 frame_tick SHALL be 1 for the cycle in which pwm_cnt==LEVEL_MAX-1 and enable==1.
REQ-014 On step, pattern_in SHALL be latched into pat_q and pend set to 1.
REQ-015 On the frame_tick cycle with pend==1, each level[i] SHALL become LEVEL_MAX if pat_q[i]==1, else max(level[i]-DECAY, 0); pend clears.
REQ-016 Subtraction SHALL saturate at 0; no wrap-around to high levels.
REQ-017 A frame_tick with pend==0 SHALL leave all levels unchanged; decay occurs only on applied steps.
REQ-018 step coincident with an applying frame_tick: update SHALL use the old pat_q; the new pattern SHALL be latched, pend stays 1, and it applies at the next frame_tick; overrun is not set.
REQ-019 step while pend==1 and no apply in that cycle: pat_q SHALL be overwritten and overrun set to 1 until reset.
REQ-020 led_out[i] SHALL be registered as (level[i] > pwm_cnt) && enable, one cycle after the compare; level LEVEL_MAX gives 100% on, level 0 gives 0%.
REQ-021 New levels SHALL take effect starting from the first cycle of the following frame (pwm_cnt==0 compare), never mid-frame.
REQ-022 enable==0: pwm_cnt SHALL hold at 0, led_out SHALL be 0 from the next cycle, frame_tick 0, levels hold; step SHALL still latch per REQ-014/019.
REQ-023 enable rising: PWM SHALL restart with pwm_cnt=0.

Reset
REQ-024 rst_n low SHALL asynchronously clear level[*], pwm_cnt, pat_q, pend, overrun, frame_tick and led_out to 0.
REQ-025 Reset asserted mid-frame SHALL discard any pending step; after release the first frame starts at pwm_cnt=0.

Structure
REQ-026 Shared package led_fade_pkg SHALL hold WIDTH, LEVEL_BITS, LEVEL_MAX and DECAY defaults, plus the saturating-decrement function.
REQ-027 Per-LED logic (level register, saturating update, compare, output flop) SHALL be sub-module led_pwm_channel, instantiated WIDTH times by generate.
REQ-028 pwm_cnt, pat_q, pend and overrun SHALL live in the top level and be shared by all channels.

Verification
REQ-029 Reset mid-frame with levels nonzero -> led_out=0x00, overrun=0 immediately; first frame_tick 15 cycles after release with enable=1.
REQ-030 step with pattern_in=0x80 -> after next frame_tick, led_out[7]=1 for all 15 cycles of each frame, led_out[6:0]=0.
REQ-031 Then step with 0x40 (DECAY=4) -> next frame led_out[7] high 11 of 15 cycles, led_out[6] high 15 of 15; steps 0x20,0x10,0x08 -> led_out[7] duty 7,3,0 (saturation, no wrap).
REQ-032 Two steps (0x01 then 0x02) in one frame -> overrun=1, only 0x02 applied (led_out[1] 15/15, led_out[0] 0/15).
REQ-033 step 0x04 on the frame_tick cycle while pend holds 0x08 -> 0x08 applied this frame, 0x04 next frame, overrun stays 0.
REQ-034 enable=0 for 40 cycles with steps issued -> led_out=0, frame_tick absent, levels unchanged; enable=1 -> pwm_cnt restarts at 0 and pending step applies at the first frame_tick.
